hex_entry_buffer: RTL and testbench

Consumes the one-hot-decoded switch stage's outputs: a 4-bit hex digit and its one-cycle pulse. Assembles successive digits, most-recent-last, into a multi-digit number for the seven-segment display path. Supports backspace and clear. Hands the finished number downstream through a valid/ready handshake on a commit strobe.

---
 rtl/hex_entry_buffer_pkg.sv | 13 +
 rtl/hex_entry_buffer_digit_shift_reg.sv | 57 +++++
 rtl/hex_entry_buffer.sv | 110 +++++++++++
 tb/tb_hex_entry_buffer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_buffer_pkg.sv
// Shared types and constants for the hex digit entry buffer.
// Included by the shift register and by the top-level controller.
package hex_entry_buffer_pkg;

   localparam int DEFAULT_DIGITS = 8;
   localparam int HEX_W          = 4;

   typedef enum logic {
      ENTRY = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/hex_entry_buffer_digit_shift_reg.sv
// Digit storage: newest digit in the low nibble, with a digit counter.
// Shift-in is blocked when full and shift-out is blocked when empty, so the counter never wraps.
module digit_shift_reg
   import hex_entry_buffer_pkg::*;
#(
   parameter int DIGITS = DEFAULT_DIGITS,
   parameter int CNT_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      do_clear,
   input  logic                      do_shl,
   input  logic                      do_shr,
   input  logic [HEX_W-1:0]          hex,
   output logic [HEX_W*DIGITS-1:0]   value,
   output logic [CNT_W-1:0]          count,
   output logic                      full,
   output logic                      empty
);

   localparam int VW = HEX_W * DIGITS;

   logic [VW-1:0]    value_q, value_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign full  = (count_q == CNT_W'(DIGITS));
   assign empty = (count_q == '0);

   always_comb begin
      value_d = value_q;
      count_d = count_q;
      if (do_clear) begin
         value_d = '0;
         count_d = '0;
      end else if (do_shr && !empty) begin
         value_d = value_q >> HEX_W;
         count_d = count_q - CNT_W'(1);
      end else if (do_shl && !full) begin
         value_d = {value_q[VW-HEX_W-1:0], hex};
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         count_q <= count_d;
      end
   end

   assign value = value_q;
   assign count = count_q;

endmodule

// File: rtl/hex_entry_buffer.sv
// Hex digit entry buffer: edit controller around the digit shift register,
// handing a committed number downstream over a valid/ready handshake.
//
//   state | meaning
//   ENTRY | accepting digits, delete, clear and commit
//   HOLD  | committed number on out_data, waiting for out_ready
module hex_entry_buffer
   import hex_entry_buffer_pkg::*;
#(
   parameter int DIGITS = DEFAULT_DIGITS,
   parameter int CNT_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [HEX_W-1:0]        hex,
   input  logic                    pulse,
   input  logic                    del,
   input  logic                    clear,
   input  logic                    commit,
   output logic [HEX_W*DIGITS-1:0] value,
   output logic [CNT_W-1:0]        count,
   output logic                    full,
   output logic                    out_valid,
   output logic [HEX_W*DIGITS-1:0] out_data,
   input  logic                    out_ready,
   output logic                    err
);

   localparam int VW = HEX_W * DIGITS;

   state_e        state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic [VW-1:0] out_data_q, out_data_d;
   logic          err_q, err_d;
   logic          do_clear, do_shl, do_shr;
   logic          empty;

   digit_shift_reg #(
      .DIGITS (DIGITS),
      .CNT_W  (CNT_W)
   ) u_digits (
      .clk      (clk),
      .rst      (rst),
      .do_clear (do_clear),
      .do_shl   (do_shl),
      .do_shr   (do_shr),
      .hex      (hex),
      .value    (value),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = 1'b0;
      do_clear    = 1'b0;
      do_shl      = 1'b0;
      do_shr      = 1'b0;
      unique case (state_q)
         ENTRY: begin
            // An asserted commit on an empty entry still outranks del/pulse.
            if (clear) begin
               do_clear = 1'b1;
            end else if (commit) begin
               if (!empty) begin
                  out_data_d  = value;
                  out_valid_d = 1'b1;
                  state_d     = HOLD;
               end
            end else if (del) begin
               do_shr = 1'b1;
            end else if (pulse) begin
               if (full) err_d  = 1'b1;
               else      do_shl = 1'b1;
            end
         end
         HOLD: begin
            if (pulse) err_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               do_clear    = 1'b1;
               state_d     = ENTRY;
            end
         end
         default: state_d = ENTRY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ENTRY;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err       = err_q;

endmodule

// File: tb/tb_hex_entry_buffer.sv
// Directed self-checking bench for hex_entry_buffer with hand-computed expectations.
module tb_hex_entry_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  hex = '0;
   logic        pulse = 1'b0, del = 1'b0, clear = 1'b0, commit = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] value, out_data;
   logic [3:0]  count;
   logic        full, out_valid, err;

   int checks = 0;
   int failures = 0;
   int err_hits = 0;

   hex_entry_buffer #(.DIGITS(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .hex       (hex),
      .pulse     (pulse),
      .del       (del),
      .clear     (clear),
      .commit    (commit),
      .value     (value),
      .count     (count),
      .full      (full),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Advance one edge and sample 1 time unit later; counts err-high cycles.
   task automatic tick();
      @(posedge clk);
      #1;
      if (err === 1'b1) err_hits++;
   endtask

   task automatic send_pulse(input logic [3:0] h);
      hex = h; pulse = 1'b1; tick(); pulse = 1'b0;
   endtask

   task automatic send_del();
      del = 1'b1; tick(); del = 1'b0;
   endtask

   task automatic send_clear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; pulse = 1'b1; hex = 4'hF; tick(); tick();
      rst = 1'b0; pulse = 1'b0;
      checks++; if (value !== 32'h0) begin failures++; $display("FAIL reset_value got=%h exp=%h", value, 32'h0); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
   endtask

   task automatic test_entry();
      logic [3:0] digs [3] = '{4'h1, 4'h2, 4'h3};
      err_hits = 0;
      for (int i = 0; i < 3; i++) begin
         send_pulse(digs[i]);
         tick(); tick();
      end
      checks++; if (value !== 32'h00000123) begin failures++; $display("FAIL entry_value got=%h exp=00000123", value); end
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL entry_count got=%0d exp=3", count); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL entry_full got=%b exp=0", full); end
      checks++; if (err_hits !== 0) begin failures++; $display("FAIL entry_err got=%0d exp=0", err_hits); end
   endtask

   task automatic test_full();
      logic [3:0] digs [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0};
      send_clear();
      for (int i = 0; i < 8; i++) send_pulse(digs[i]);
      checks++; if (value !== 32'h12345670) begin failures++; $display("FAIL full_value got=%h exp=12345670", value); end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
      checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
      err_hits = 0;
      send_pulse(4'h5);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL full_err_rise got=%b exp=1", err); end
      checks++; if (value !== 32'h12345670) begin failures++; $display("FAIL full_value_kept got=%h exp=12345670", value); end
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_err_fall got=%b exp=0", err); end
      checks++; if (err_hits !== 1) begin failures++; $display("FAIL full_err_cycles got=%0d exp=1", err_hits); end
   endtask

   task automatic test_del();
      send_clear();
      send_pulse(4'h1); send_pulse(4'h2); send_pulse(4'h3);
      send_del();
      checks++; if (value !== 32'h12) begin failures++; $display("FAIL del1_value got=%h exp=12", value); end
      checks++; if (count !== 4'd2) begin failures++; $display("FAIL del1_count got=%0d exp=2", count); end
      send_del(); send_del();
      checks++; if (value !== 32'h0 || count !== 4'd0) begin failures++; $display("FAIL del3 got=%h/%0d exp=0/0", value, count); end
      err_hits = 0;
      send_del(); tick();
      checks++; if (value !== 32'h0 || count !== 4'd0) begin failures++; $display("FAIL del_empty got=%h/%0d exp=0/0", value, count); end
      checks++; if (err_hits !== 0) begin failures++; $display("FAIL del_empty_err got=%0d exp=0", err_hits); end
   endtask

   task automatic test_hold();
      send_pulse(4'h1); send_pulse(4'h2);
      out_ready = 1'b0;
      commit = 1'b1; tick(); commit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== 32'h12) begin failures++; $display("FAIL hold_cycle%0d got=%b/%h exp=1/12", i, out_valid, out_data); end
         tick();
      end
      send_pulse(4'h9);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL hold_pulse_err got=%b exp=1", err); end
      checks++; if (value !== 32'h12) begin failures++; $display("FAIL hold_pulse_value got=%h exp=12", value); end
      send_del(); send_clear();
      checks++; if (value !== 32'h12 || out_valid !== 1'b1) begin failures++; $display("FAIL hold_ignore got=%h/%b exp=12/1", value, out_valid); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_accept_valid got=%b exp=0", out_valid); end
      checks++; if (value !== 32'h0 || count !== 4'd0) begin failures++; $display("FAIL hold_accept_entry got=%h/%0d exp=0/0", value, count); end
   endtask

   task automatic test_commit_edges();
      commit = 1'b1; tick(); commit = 1'b0; tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL commit_empty got=%b exp=0", out_valid); end
      send_pulse(4'h7);
      hex = 4'hA; pulse = 1'b1; commit = 1'b1; tick(); pulse = 1'b0; commit = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h7) begin failures++; $display("FAIL commit_pulse got=%b/%h exp=1/7", out_valid, out_data); end
      checks++; if (value !== 32'h7 || count !== 4'd1) begin failures++; $display("FAIL commit_pulse_drop got=%h/%0d exp=7/1", value, count); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      send_pulse(4'h3);
      clear = 1'b1; commit = 1'b1; tick(); clear = 1'b0; commit = 1'b0;
      checks++; if (value !== 32'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL clear_commit got=%h/%b exp=0/0", value, out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send_pulse(4'hC);
      commit = 1'b1; tick(); commit = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hC) begin failures++; $display("FAIL b2b_commit got=%b/%h exp=1/c", out_valid, out_data); end
      hex = 4'hB; pulse = 1'b1; err_hits = 0; tick(); pulse = 1'b0;
      checks++; if (out_valid !== 1'b0 || value !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b/%h/%b exp=0/0/1", out_valid, value, err); end
      send_pulse(4'hD);
      checks++; if (value !== 32'hD || count !== 4'd1) begin failures++; $display("FAIL b2b_edit got=%h/%0d exp=d/1", value, count); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_in_hold();
      send_clear();
      send_pulse(4'h5);
      commit = 1'b1; tick(); commit = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rsthold_pre got=%b exp=1", out_valid); end
      rst = 1'b1; out_ready = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || value !== 32'h0) begin failures++; $display("FAIL rsthold_post got=%b/%h/%h exp=0/0/0", out_valid, out_data, value); end
      send_pulse(4'h4);
      checks++; if (value !== 32'h4 || count !== 4'd1) begin failures++; $display("FAIL rsthold_entry got=%h/%0d exp=4/1", value, count); end
   endtask

   initial begin
      #2;
      test_reset();
      test_entry();
      test_full();
      test_del();
      test_hold();
      test_commit_edges();
      test_back_to_back();
      test_reset_in_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
